// File: rtl/perif_buf.sv
// perif_buf: four-phase request/acknowledge receiver feeding a show-ahead word buffer.
// Latency: send sampled at edge N -> word stored and ack=1 after edge N+1; out_data is combinational from the head.
// Backpressure: while full (count before any same-cycle pop) new requests stall in IDLE with ack=0.
// Optional build macro PERIF_PARITY_EN adds input par and sticky output parity_err; bad-parity words are dropped.
module perif_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       send,
  input  logic [WIDTH-1:0]           data,
`ifdef PERIF_PARITY_EN
  input  logic                       par,
  output logic                       parity_err,
`endif
  output logic                       ack,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    ACK     = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             wr_en;
  logic             pop;
  logic             par_ok;

  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign out_data  = mem[head];
  assign pop       = out_valid & out_ready;
  assign ack       = (state == ACK);

`ifdef PERIF_PARITY_EN
  // even parity over data plus par must come out zero for the word to be kept
  assign par_ok = ~(^{data, par});
`else
  assign par_ok = 1'b1;
`endif

  assign wr_en = (state == CAPTURE) & par_ok;

  // handshake state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state decode; full here is the pre-pop count, so a pop in the same cycle still stalls once
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = (send && !full) ? CAPTURE : IDLE;
      CAPTURE: state_nxt = ACK;
      ACK:     state_nxt = send ? ACK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // buffer storage, written at tail during CAPTURE; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[tail] <= data;
  end

  // pointers and occupancy; a write and pop together leave count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) tail <= tail + 1'b1;
      if (pop)   head <= head + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
    end
  end

`ifdef PERIF_PARITY_EN
  // sticky parity error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)                          parity_err <= 1'b0;
    else if (state == CAPTURE && !par_ok) parity_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_perif_buf.sv
// tb_perif_buf: directed checks of perif_buf at WIDTH=8, DEPTH=4.
// Latency: expects ack two edges after send is raised from IDLE.
// Backpressure: exercises full stall, concurrent pop, wrap-around and reset mid-handshake.
module tb_perif_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [7:0] data;
  logic       ack;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] count;
  logic       full;
`ifdef PERIF_PARITY_EN
  logic       par;
  logic       parity_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic       mon_en = 1'b0;
  logic [7:0] expq[$];

  perif_buf #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .data      (data),
`ifdef PERIF_PARITY_EN
    .par       (par),
    .parity_err(parity_err),
`endif
    .ack       (ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // raise send with a word, wait (bounded) for ack, then drop send and see ack fall
  task automatic xfer(input logic [7:0] d, output int waited);
    send   = 1'b1;
    data   = d;
    waited = 0;
    while (!ack && waited < 20) begin
      tick();
      waited++;
    end
    chk("xfer_ack", {31'b0, ack}, 32'd1);
    send = 1'b0;
    tick();
    chk("xfer_ack_drop", {31'b0, ack}, 32'd0);
  endtask

  // pop-side scoreboard, sampled on the falling edge before the popping rising edge
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_count_le1", {31'b0, (count <= 3'd1)}, 32'd1);
      if (out_valid && out_ready) begin
        logic [8:0] e;
        e = (expq.size() > 0) ? {1'b0, expq.pop_front()} : 9'h1FF;
        chk("mon_order", {23'b0, 1'b0, out_data}, {23'b0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; send = 1'b0; data = 8'h00; out_ready = 1'b0;
`ifdef PERIF_PARITY_EN
    par = 1'b0;
`endif
    tick(); tick();
    chk("rst_ack",   {31'b0, ack},       32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_full",  {31'b0, full},      32'd0);
    chk("rst_count", {29'b0, count},     32'd0);
`ifdef PERIF_PARITY_EN
    chk("rst_perr",  {31'b0, parity_err}, 32'd0);
`endif
    rst = 1'b0;
    tick();

    // single transfer: ack exactly two edges after send
    send = 1'b1; data = 8'hA5;
    tick();
    chk("single_ack_n", {31'b0, ack}, 32'd0);
    chk("single_valid_n", {31'b0, out_valid}, 32'd0);
    tick();
    chk("single_ack_n1", {31'b0, ack},       32'd1);
    chk("single_valid",  {31'b0, out_valid}, 32'd1);
    chk("single_data",   {24'b0, out_data},  32'hA5);
    chk("single_count",  {29'b0, count},     32'd1);
    send = 1'b0;
    tick();
    chk("single_ack_drop", {31'b0, ack}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("single_pop_count", {29'b0, count}, 32'd0);
    tick();
    chk("empty_pop_ignored", {29'b0, count},   32'd0);
    chk("empty_valid",       {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // fill and stall
    for (int i = 1; i <= 4; i++) begin
      xfer(8'(i), w);
      chk("fill_latency", w, 32'd2);
    end
    chk("fill_count", {29'b0, count}, 32'd4);
    chk("fill_full",  {31'b0, full},  32'd1);
    send = 1'b1; data = 8'h05;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ack", {31'b0, ack}, 32'd0);
    end
    chk("stall_count", {29'b0, count}, 32'd4);
    chk("stall_head",  {24'b0, out_data}, 32'h01);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_pop_count", {29'b0, count}, 32'd3);
    chk("stall_pop_ack",   {31'b0, ack},   32'd0);
    xfer(8'h05, w);
    chk("stall_resume", w, 32'd2);
    chk("stall_refill", {29'b0, count}, 32'd4);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("drain_data", {24'b0, out_data}, 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_count", {29'b0, count}, 32'd0);

    // concurrent traffic with constant out_ready
    for (int i = 0; i < 10; i++) expq.push_back(8'h20 + 8'(i));
    out_ready = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      xfer(8'h20 + 8'(i), w);
      chk("cc_nostall", w, 32'd2);
    end
    tick();
    mon_en = 1'b0;
    out_ready = 1'b0;
    chk("cc_drained", expq.size(), 32'd0);
    chk("cc_count",   {29'b0, count}, 32'd0);

    // wrap-around with simultaneous write and pop
    xfer(8'h10, w);
    for (int i = 1; i <= 5; i++) begin
      send = 1'b1; data = 8'h10 + 8'(i);
      tick();
      chk("wrap_head", {24'b0, out_data}, 32'(8'h10 + 8'(i - 1)));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("wrap_ack",   {31'b0, ack},      32'd1);
      chk("wrap_count", {29'b0, count},    32'd1);
      chk("wrap_data",  {24'b0, out_data}, 32'(8'h10 + 8'(i)));
      send = 1'b0;
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("wrap_empty", {29'b0, count}, 32'd0);

    // reset while in ACK with two words buffered
    xfer(8'h30, w);
    send = 1'b1; data = 8'h31;
    tick(); tick();
    chk("mid_ack",   {31'b0, ack},   32'd1);
    chk("mid_count", {29'b0, count}, 32'd2);
    rst = 1'b1;
    tick();
    chk("mid_rst_ack",   {31'b0, ack},       32'd0);
    chk("mid_rst_count", {29'b0, count},     32'd0);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0;
    tick();
    chk("mid_recap_n", {31'b0, ack}, 32'd0);
    tick();
    chk("mid_recap_ack",   {31'b0, ack},      32'd1);
    chk("mid_recap_count", {29'b0, count},    32'd1);
    chk("mid_recap_data",  {24'b0, out_data}, 32'h31);
    send = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

`ifdef PERIF_PARITY_EN
    // bad parity word dropped but acknowledged; flag is sticky
    par = 1'b1;
    xfer(8'h03, w);
    chk("par_bad_count", {29'b0, count},      32'd0);
    chk("par_bad_valid", {31'b0, out_valid},  32'd0);
    chk("par_bad_err",   {31'b0, parity_err}, 32'd1);
    par = 1'b0;
    xfer(8'h03, w);
    chk("par_good_count", {29'b0, count},      32'd1);
    chk("par_good_data",  {24'b0, out_data},   32'h03);
    chk("par_sticky",     {31'b0, parity_err}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/perif_buf.md
PERIF_BUF -- requirements
Module: perif_buf

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, receive buffer depth in words (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 send  input  1  sender request, four-phase handshake.
REQ-006 data  input  WIDTH  sender word, stable while send=1.
REQ-007 ack  output  1  receiver acknowledge, four-phase handshake.
REQ-008 out_valid  output  1  buffer holds at least one word.
REQ-009 out_data  output  WIDTH  oldest buffered word, valid when out_valid=1.
REQ-010 out_ready  input  1  consumer pops head when out_valid=1 and out_ready=1.
REQ-011 count  output  $clog2(DEPTH)+1  number of buffered words, 0..DEPTH.
REQ-012 full  output  1  count==DEPTH.

Function
REQ-013 Handshake FSM SHALL have states IDLE=2'b00, CAPTURE=2'b01, ACK=2'b10; any other encoding SHALL go to IDLE next cycle.
REQ-014 IDLE: send=1 and full=0 -> CAPTURE; send=1 and full=1 -> stay IDLE (stall, ack=0); send=0 -> stay IDLE.
REQ-015 CAPTURE: data SHALL be written to buffer at tail on this edge; -> ACK unconditionally.
REQ-016 ACK: send=0 -> IDLE; send=1 -> stay ACK.
REQ-017 ack SHALL be Moore-decoded: 1 only in ACK, 0 in all other states.
REQ-018 Latency: send rising sampled at edge N -> word written and ack=1 after edge N+1.
REQ-019 full evaluated in IDLE SHALL use count before any same-cycle pop (conservative; one extra stall cycle allowed).
REQ-020 out_valid SHALL equal (count!=0); out_data SHALL present head word combinationally from buffer storage (show-ahead).
REQ-021 Pop (out_valid & out_ready) SHALL advance head pointer; out_ready with out_valid=0 SHALL be ignored.
REQ-022 Simultaneous write and pop SHALL leave count unchanged and both pointers advance.
REQ-023 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow below 0.
REQ-024 Words SHALL be delivered in arrival order, unmodified, with no loss or duplication.

Reset
REQ-025 rst=1 at an edge SHALL set state IDLE, head/tail 0, count 0; thus ack=0, out_valid=0, full=0 after that edge.
REQ-026 Buffer contents need not be cleared; out_data is don't-care while out_valid=0.
REQ-027 Reset mid-handshake SHALL abort it; if send is still 1 after rst deasserts, a new transfer SHALL start and capture data again.

Configuration
REQ-028 Macro PERIF_PARITY_EN SHALL add input port par (1 bit, even parity over data) and output parity_err (1 bit, sticky).
REQ-029 With PERIF_PARITY_EN: in CAPTURE, if ^{data,par}!=0 the word SHALL be dropped (not written), parity_err SHALL set to 1, FSM still -> ACK; parity_err clears only on rst.
REQ-030 Without PERIF_PARITY_EN: ports par/parity_err SHALL not exist; every captured word SHALL be written.

Verification (WIDTH=8, DEPTH=4)
REQ-031 Single transfer: send=1, data=8'hA5 from reset -> ack=1 two edges later, out_valid=1, out_data=8'hA5, count=1; send=0 -> ack=0 next edge.
REQ-032 Fill and stall: 5 back-to-back transfers 8'h01..8'h05, out_ready=0 -> first 4 acked, count=4, full=1; fifth holds ack=0 until one pop, then acked; pops yield 01,02,03,04,05.
REQ-033 Concurrent traffic: out_ready=1 constantly during 10 transfers -> count never exceeds 1, order preserved, no stall.
REQ-034 Wrap-around: 6 write/pop cycles at DEPTH=4 -> pointers wrap, data 8'h10..8'h15 in order.
REQ-035 Reset mid-handshake: rst=1 while in ACK with count=2 -> next edge ack=0, count=0, out_valid=0; send held 1 -> new capture after rst=0.
REQ-036 PERIF_PARITY_EN: data=8'h03, par=1 -> acked, not buffered, count=0, parity_err=1; then data=8'h03, par=0 -> buffered, parity_err stays 1.
